rf_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback requesters: req0 = ALU/execute, req1 = load/store unit.
- Tracks a busy scoreboard of destination registers so the issue logic can stall on read-after-write hazards.
- Sits between the execute/LSU stages and the register file.
- Drives the register file's write_enable, write_addr and write_data from a registered output stage.

---
 rtl/rf_pkg.sv | 15 +
 rtl/rr_arb2.sv | 31 +++
 rtl/rf_wb_arbiter.sv | 106 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared defaults and types for the register-file writeback arbiter.
package rf_pkg;
  localparam int RF_WIDTH  = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NREG   = 2 ** RF_ADDR_W;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_WIDTH-1:0]  rf_data_t;

  typedef struct packed {
    logic     valid;
    rf_addr_t addr;
    rf_data_t data;
  } wb_req_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer only moves when both requesters contend.
module rr_arb2
  import rf_pkg::*;
#(
  parameter bit FAIR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt   = req;
    ptr_d = ptr_q;
    if (req == 2'b11) begin
      gnt        = 2'b00;
      gnt[ptr_q] = 1'b1;
      ptr_d      = ~ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) ptr_q <= FAIR_INIT;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter with busy scoreboard and a registered write stage.
// Optional write-stage forwarding ports are built when WB_FWD_EN is defined.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int WIDTH     = RF_WIDTH,
  parameter int ADDR_W    = RF_ADDR_W,
  parameter bit FAIR_INIT = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_valid,
  input  logic [ADDR_W-1:0]      req0_addr,
  input  logic [WIDTH-1:0]       req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [ADDR_W-1:0]      req1_addr,
  input  logic [WIDTH-1:0]       req1_data,
  output logic                   req1_ready,
  input  logic                   rsv_valid,
  input  logic [ADDR_W-1:0]      rsv_addr,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_waddr,
  output logic [WIDTH-1:0]       rf_wdata,
  output logic [2**ADDR_W-1:0]   rf_busy
`ifdef WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0]      fwd_addr1,
  input  logic [ADDR_W-1:0]      fwd_addr2,
  output logic                   fwd_hit1,
  output logic                   fwd_hit2,
  output logic [WIDTH-1:0]       fwd_data1,
  output logic [WIDTH-1:0]       fwd_data2
`endif
);

  localparam int NREG = 2 ** ADDR_W;

  logic [1:0]        gnt;
  logic              xfer;
  logic              wr_ok;
  logic [ADDR_W-1:0] xfer_addr;
  logic [WIDTH-1:0]  xfer_data;

  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [WIDTH-1:0]  wdata_q;
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;

  rr_arb2 #(.FAIR_INIT(FAIR_INIT)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({req1_valid, req0_valid}),
    .gnt   (gnt)
  );

  assign req0_ready = reset & gnt[0];
  assign req1_ready = reset & gnt[1];

  always_comb begin
    xfer      = req0_ready | req1_ready;
    xfer_addr = req1_ready ? req1_addr : req0_addr;
    xfer_data = req1_ready ? req1_data : req0_data;
    wr_ok     = xfer && (xfer_addr != '0);
  end

  // Reserve is applied after clear so a same-address reserve keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) busy_d[xfer_addr] = 1'b0;
    if (rsv_valid && (rsv_addr != '0)) busy_d[rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      we_q   <= wr_ok;
      busy_q <= busy_d;
      if (wr_ok) begin
        waddr_q <= xfer_addr;
        wdata_q <= xfer_data;
      end
    end
  end

  assign rf_we    = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign rf_busy  = busy_q;

`ifdef WB_FWD_EN
  always_comb begin
    fwd_hit1  = we_q && (waddr_q == fwd_addr1) && (fwd_addr1 != '0);
    fwd_hit2  = we_q && (waddr_q == fwd_addr2) && (fwd_addr2 != '0);
    fwd_data1 = fwd_hit1 ? wdata_q : '0;
    fwd_data2 = fwd_hit2 ? wdata_q : '0;
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized self-checking bench for rf_wb_arbiter against a cycle-level reference model.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;
  localparam bit FAIR_INIT = 1'b0;

  logic clk = 1'b0;
  logic reset;
  logic req0_valid, req1_valid, rsv_valid;
  logic [ADDR_W-1:0] req0_addr, req1_addr, rsv_addr;
  logic [WIDTH-1:0]  req0_data, req1_data;
  logic req0_ready, req1_ready, rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [WIDTH-1:0]  rf_wdata;
  logic [NREG-1:0]   rf_busy;
`ifdef WB_FWD_EN
  logic [ADDR_W-1:0] fwd_addr1, fwd_addr2;
  logic fwd_hit1, fwd_hit2;
  logic [WIDTH-1:0] fwd_data1, fwd_data2;
`endif

  always #5 clk = ~clk;

  rf_wb_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .FAIR_INIT(FAIR_INIT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_busy(rf_busy)
`ifdef WB_FWD_EN
    , .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: who holds priority, the pending-writer set and the expected write port.
  int      m_prio;
  bit      m_busy [NREG];
  bit      m_we;
  int      m_waddr;
  logic [WIDTH-1:0] m_wdata;
  int      last_g;

  function automatic logic [NREG-1:0] busy_vec();
    logic [NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Inputs are already driven (just after a negedge). Checks combinational
  // outputs, advances the model across the posedge and checks registered outputs.
  task automatic step();
    int g;
    wb_req_t win;
    #1;
    g = -1;
    if (req0_valid && req1_valid) g = m_prio;
    else if (req0_valid)          g = 0;
    else if (req1_valid)          g = 1;
    if (!reset) g = -1;
    check_val("req0_ready", 64'(req0_ready), 64'(g == 0));
    check_val("req1_ready", 64'(req1_ready), 64'(g == 1));
`ifdef WB_FWD_EN
    check_val("fwd_hit1", 64'(fwd_hit1), 64'(m_we && m_waddr == int'(fwd_addr1) && fwd_addr1 != 0));
    check_val("fwd_hit2", 64'(fwd_hit2), 64'(m_we && m_waddr == int'(fwd_addr2) && fwd_addr2 != 0));
    check_val("fwd_data1", 64'(fwd_data1), (m_we && m_waddr == int'(fwd_addr1) && fwd_addr1 != 0) ? 64'(m_wdata) : 64'd0);
    check_val("fwd_data2", 64'(fwd_data2), (m_we && m_waddr == int'(fwd_addr2) && fwd_addr2 != 0) ? 64'(m_wdata) : 64'd0);
`endif
    if (!reset) begin
      m_prio = int'(FAIR_INIT);
      m_we = 0; m_waddr = 0; m_wdata = '0;
      for (int i = 0; i < NREG; i++) m_busy[i] = 0;
    end else begin
      if (req0_valid && req1_valid) m_prio = 1 - g;
      m_we = 0;
      if (g >= 0) begin
        win.valid = 1'b1;
        win.addr  = (g == 0) ? req0_addr : req1_addr;
        win.data  = (g == 0) ? req0_data : req1_data;
        if (win.addr != 0) begin
          m_we = 1; m_waddr = int'(win.addr); m_wdata = win.data;
          m_busy[win.addr] = 0;
        end
      end
      if (rsv_valid && rsv_addr != 0) m_busy[rsv_addr] = 1;
    end
    last_g = g;
    @(posedge clk);
    @(negedge clk);
    check_val("rf_we", 64'(rf_we), 64'(m_we));
    check_val("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
    check_val("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
    check_val("rf_busy", 64'(rf_busy), 64'(busy_vec()));
  endtask

  task automatic idle();
    req0_valid = 0; req1_valid = 0; rsv_valid = 0;
  endtask

  initial begin
    int exp_seq [4];
    reset = 0; idle();
    req0_addr = 0; req1_addr = 0; rsv_addr = 0; req0_data = 0; req1_data = 0;
`ifdef WB_FWD_EN
    fwd_addr1 = 0; fwd_addr2 = 0;
`endif
    m_prio = 0; m_we = 0; m_waddr = 0; m_wdata = '0; last_g = -1;
    for (int i = 0; i < NREG; i++) m_busy[i] = 0;
    @(negedge clk);
    step(); step();
    check_val("reset_busy", 64'(rf_busy), 64'd0);
    check_val("reset_we", 64'(rf_we), 64'd0);
    reset = 1;

    // Single request with a prior reservation of the same register.
    rsv_valid = 1; rsv_addr = 5; step();
    check_val("rsv5_busy", 64'(rf_busy[5]), 64'd1);
    rsv_valid = 0;
    req0_valid = 1; req0_addr = 5; req0_data = 32'hDEADBEEF; step();
    check_val("single_we", 64'(rf_we), 64'd1);
    check_val("single_waddr", 64'(rf_waddr), 64'd5);
    check_val("single_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    check_val("single_busy5", 64'(rf_busy[5]), 64'd0);

    // Contention: grants alternate starting with requester 0.
    exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 1; exp_seq[3] = 2;
    req0_valid = 1; req0_addr = 1; req1_valid = 1; req1_addr = 2;
    for (int k = 0; k < 4; k++) begin
      req0_data = 32'h100 + k; req1_data = 32'h200 + k;
      step();
      check_val("contend_waddr", 64'(rf_waddr), 64'(exp_seq[k]));
    end
    idle();

    // Write to x0 is accepted but suppressed.
    req1_valid = 1; req1_addr = 0; req1_data = 32'h1234; step();
    check_val("x0_we", 64'(rf_we), 64'd0);
    idle();

    // Reserve and clear of the same register in one cycle: reserve wins.
    rsv_valid = 1; rsv_addr = 7; step();
    req0_valid = 1; req0_addr = 7; req0_data = 32'h77; step();
    check_val("collide_busy7", 64'(rf_busy[7]), 64'd1);
    rsv_valid = 0; req0_data = 32'h78; step();
    check_val("clear_busy7", 64'(rf_busy[7]), 64'd0);
    idle();

`ifdef WB_FWD_EN
    req0_valid = 1; req0_addr = 3; req0_data = 32'hCAFE0003; step();
    idle(); fwd_addr1 = 3; fwd_addr2 = 0;
    #1;
    check_val("fwd_tp_hit1", 64'(fwd_hit1), 64'd1);
    check_val("fwd_tp_data1", 64'(fwd_data1), 64'hCAFE0003);
    check_val("fwd_tp_hit2", 64'(fwd_hit2), 64'd0);
    step();
`endif

    // Reset mid-operation after moving the pointer away from FAIR_INIT.
    rsv_valid = 1; rsv_addr = 9;
    req0_valid = 1; req0_addr = 4; req1_valid = 1; req1_addr = 6; step();
    rsv_valid = 0; req0_valid = 0; step();
    idle(); req0_valid = 1; req0_addr = 9; req0_data = 32'h99; step();
    idle(); reset = 0; step();
    check_val("midrst_we", 64'(rf_we), 64'd0);
    check_val("midrst_busy", 64'(rf_busy), 64'd0);
    reset = 1;
    req0_valid = 1; req0_addr = 10; req1_valid = 1; req1_addr = 11;
    #1;
    check_val("midrst_prio", 64'(req0_ready), 64'(!FAIR_INIT));
    step();
    idle();

    // Randomized phase: requesters hold their request until granted.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 79) != 0);
      if (!(req0_valid && last_g != 0)) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_addr  = ADDR_W'($urandom_range(0, 7));
        req0_data  = $urandom;
      end
      if (!(req1_valid && last_g != 1)) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_addr  = ADDR_W'($urandom_range(0, 7));
        req1_data  = $urandom;
      end
      rsv_valid = ($urandom_range(0, 1) != 0);
      rsv_addr  = ADDR_W'($urandom_range(0, 7));
`ifdef WB_FWD_EN
      fwd_addr1 = ADDR_W'($urandom_range(0, 7));
      fwd_addr2 = ADDR_W'($urandom_range(0, 7));
`endif
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
